// File: rtl/ucsbece154b_icache.sv
// ucsbece154b_icache: set-associative read-only instruction cache with
// zero-latency hits and a burst refill from main memory on a miss.
// Optional build macro: ICACHE_EARLY_RESTART_EN (release fetch on the
// requested word as it arrives, instead of in DONE).
`timescale 1ns/1ps

module ucsbece154b_icache #(
    parameter int unsigned NUM_SETS    = 8,
    parameter int unsigned NUM_WAYS    = 4,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable_i,
    input  logic [31:0] ReadAddress_i,
    output logic [31:0] Instruction_o,
    output logic        Ready_o,
    output logic        MemReadRequest_o,
    output logic [31:0] MemReadAddress_o,
    input  logic [31:0] MemDataIn_i,
    input  logic        MemDataReady_i
);

    localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W = 32 - OFF_W - IDX_W - 2;
    localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned CNT_W = OFF_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Lookup address fields; the byte offset is not used by a word cache.
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_byte_off;

    assign req_off         = ReadAddress_i[2 +: OFF_W];
    assign req_idx         = ReadAddress_i[2 + OFF_W +: IDX_W];
    assign req_tag         = ReadAddress_i[31 -: TAG_W];
    assign unused_byte_off = ^ReadAddress_i[1:0];

    // Storage arrays and per-set replacement state.
    logic [31:0]         data_q  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [WAY_W-1:0]    rr_q    [NUM_SETS];

    // Miss-handling registers.
    logic [1:0]       state_q, state_d;
    logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
    logic [OFF_W-1:0] miss_off_q, miss_off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifndef ICACHE_EARLY_RESTART_EN
    logic [31:0]      word_q, word_d;
`endif

    logic             hit_c;
    logic [WAY_W-1:0] hit_way_c;
    logic [31:0]      hit_word_c;
    logic [WAY_W-1:0] victim_c;
    logic [WAY_W-1:0] rr_next_c;

    logic             ready_c;
    logic [31:0]      instr_c;
    logic             mem_req_c;
    logic [31:0]      mem_addr_c;
    logic             fill_we_c;
    logic             fill_done_c;

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
        end
    end

    assign hit_word_c = data_q[req_idx][hit_way_c][req_off];

    // Victim: lowest invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        victim_c = rr_q[miss_idx_q];
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[miss_idx_q][w]) begin
                victim_c = WAY_W'(w);
            end
        end
        rr_next_c = (rr_q[miss_idx_q] == WAY_W'(NUM_WAYS - 1)) ? '0
                  : rr_q[miss_idx_q] + WAY_W'(1);
    end

    // Next-state and output logic for the miss FSM.
    always_comb begin
        state_d     = state_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;
        miss_off_d  = miss_off_q;
        cnt_d       = cnt_q;
`ifndef ICACHE_EARLY_RESTART_EN
        word_d      = word_q;
`endif
        ready_c     = 1'b0;
        instr_c     = '0;
        mem_req_c   = 1'b0;
        mem_addr_c  = '0;
        fill_we_c   = 1'b0;
        fill_done_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_c = 1'b1;
                if (ReadEnable_i) begin
                    if (hit_c) begin
                        instr_c = hit_word_c;
                    end else begin
                        ready_c    = 1'b0;
                        miss_tag_d = req_tag;
                        miss_idx_d = req_idx;
                        miss_off_d = req_off;
                        cnt_d      = '0;
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                mem_req_c  = 1'b1;
                mem_addr_c = {miss_tag_q, miss_idx_q, {(OFF_W + 2){1'b0}}};
                state_d    = S_FILL;
            end
            S_FILL: begin
                if (MemDataReady_i) begin
                    fill_we_c = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == {1'b0, miss_off_q}) begin
`ifdef ICACHE_EARLY_RESTART_EN
                        ready_c = 1'b1;
                        instr_c = MemDataIn_i;
`else
                        word_d  = MemDataIn_i;
`endif
                    end
                    if (cnt_q == CNT_W'(BLOCK_WORDS - 1)) begin
                        fill_done_c = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            default: begin
`ifndef ICACHE_EARLY_RESTART_EN
                ready_c = 1'b1;
                instr_c = word_q;
`endif
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are forced to their idle values while reset is held.
    assign Ready_o          = ready_c & ~reset;
    assign Instruction_o    = reset ? 32'h0 : instr_c;
    assign MemReadRequest_o = mem_req_c & ~reset;
    assign MemReadAddress_o = reset ? 32'h0 : mem_addr_c;

    // Control state, valid bits and replacement pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            miss_off_q <= '0;
            cnt_q      <= '0;
`ifndef ICACHE_EARLY_RESTART_EN
            word_q     <= '0;
`endif
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            miss_off_q <= miss_off_d;
            cnt_q      <= cnt_d;
`ifndef ICACHE_EARLY_RESTART_EN
            word_q     <= word_d;
`endif
            if (fill_done_c) begin
                valid_q[miss_idx_q][victim_c] <= 1'b1;
                rr_q[miss_idx_q]              <= rr_next_c;
            end
        end
    end

    // Data and tag arrays; contents only matter once the valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_we_c) begin
            data_q[miss_idx_q][victim_c][cnt_q[OFF_W-1:0]] <= MemDataIn_i;
        end
        if (fill_done_c) begin
            tag_q[miss_idx_q][victim_c] <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// tb_ucsbece154b_icache: directed scoreboard bench for the instruction cache.
`timescale 1ns/1ps

module tb_ucsbece154b_icache;

    localparam int unsigned NUM_SETS    = 8;
    localparam int unsigned NUM_WAYS    = 4;
    localparam int unsigned BLOCK_WORDS = 4;
`ifdef ICACHE_EARLY_RESTART_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        ReadEnable_i;
    logic [31:0] ReadAddress_i;
    logic [31:0] Instruction_o;
    logic        Ready_o;
    logic        MemReadRequest_o;
    logic [31:0] MemReadAddress_o;
    logic [31:0] MemDataIn_i;
    logic        MemDataReady_i;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];

    ucsbece154b_icache #(
        .NUM_SETS    (NUM_SETS),
        .NUM_WAYS    (NUM_WAYS),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ReadEnable_i     (ReadEnable_i),
        .ReadAddress_i    (ReadAddress_i),
        .Instruction_o    (Instruction_o),
        .Ready_o          (Ready_o),
        .MemReadRequest_o (MemReadRequest_o),
        .MemReadAddress_o (MemReadAddress_o),
        .MemDataIn_i      (MemDataIn_i),
        .MemDataReady_i   (MemDataReady_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing-memory contents: word at byte address a.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'hA0 + (a >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_exp(output logic [31:0] v);
        if (exp_q.size() != 0) v = exp_q.pop_front();
        else v = 32'hFFFF_FFFF;
    endtask

    // Lookup that must hit in the same cycle.
    task automatic do_hit(input logic [31:0] addr);
        logic [31:0] e;
        ReadEnable_i  = 1'b1;
        ReadAddress_i = addr;
        exp_q.push_back(memw(addr));
        @(negedge clk);
        pop_exp(e);
        chk("hit_ready", 32'(Ready_o), 32'd1);
        chk("hit_instr", Instruction_o, e);
        chk("hit_noreq", 32'(MemReadRequest_o), 32'd0);
        @(posedge clk); #1;
        ReadEnable_i = 1'b0;
    endtask

    // Lookup that must miss, followed by a burst refill paced by pat (LSB first).
    task automatic do_miss(input logic [31:0] addr, input logic [15:0] pat,
                           input bit flush, input logic [31:0] faddr);
        logic [31:0] base;
        logic [31:0] e;
        int          k;
        base          = {addr[31:4], 4'h0};
        ReadEnable_i  = 1'b1;
        ReadAddress_i = addr;
        exp_q.push_back(memw(addr));
        @(negedge clk);
        chk("miss_ready", 32'(Ready_o), 32'd0);
        chk("miss_noreq", 32'(MemReadRequest_o), 32'd0);
        @(posedge clk); #1;
        MemDataReady_i = 1'b1;
        MemDataIn_i    = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("req_pulse", 32'(MemReadRequest_o), 32'd1);
        chk("req_addr", MemReadAddress_o, base);
        chk("req_ready", 32'(Ready_o), 32'd0);
        @(posedge clk); #1;
        k = 0;
        for (int c = 0; c < 16 && k < int'(BLOCK_WORDS); c++) begin
            if (flush && c == 2) ReadAddress_i = faddr;
            MemDataReady_i = pat[c];
            MemDataIn_i    = pat[c] ? memw(base + 32'(4 * k)) : 32'h0BAD_0BAD;
            @(negedge clk);
            chk("fill_noreq", 32'(MemReadRequest_o), 32'd0);
            if (EARLY && pat[c] && k == int'(addr[3:2])) begin
                pop_exp(e);
                chk("early_ready", 32'(Ready_o), 32'd1);
                chk("early_instr", Instruction_o, e);
            end else begin
                chk("fill_ready", 32'(Ready_o), 32'd0);
            end
            @(posedge clk); #1;
            if (pat[c]) k++;
        end
        MemDataReady_i = 1'b0;
        chk("fill_words", 32'(k), 32'(BLOCK_WORDS));
        @(negedge clk);
        if (EARLY) e = 32'h0;
        else pop_exp(e);
        chk("done_ready", 32'(Ready_o), EARLY ? 32'd0 : 32'd1);
        chk("done_instr", Instruction_o, e);
        @(posedge clk); #1;
        if (!flush) ReadEnable_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        ReadEnable_i   = 1'b0;
        ReadAddress_i  = '0;
        MemDataIn_i    = '0;
        MemDataReady_i = 1'b0;

        // Outputs while reset is held.
        @(posedge clk); @(posedge clk); #1;
        ReadEnable_i = 1'b1;
        #1;
        chk("rst_ready", 32'(Ready_o), 32'd0);
        chk("rst_req", 32'(MemReadRequest_o), 32'd0);
        chk("rst_instr", Instruction_o, 32'h0);
        chk("rst_addr", MemReadAddress_o, 32'h0);
        ReadEnable_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Idle with no request.
        @(negedge clk);
        chk("idle_ready", 32'(Ready_o), 32'd1);
        chk("idle_instr", Instruction_o, 32'h0);
        @(posedge clk); #1;

        // Cold miss, then hit in the filled block.
        do_miss(32'h0000_0008, 16'hFFFF, 1'b0, 32'h0);
        do_hit(32'h0000_000C);

        // Gapped burst 1,0,0,1,1,0,1.
        do_miss(32'h0000_0024, 16'h0059, 1'b0, 32'h0);
        do_hit(32'h0000_0020);
        do_hit(32'h0000_002C);

        // Address changes mid-fill: fill finishes, new address misses next cycle.
        do_miss(32'h0000_0048, 16'hFFFF, 1'b1, 32'h0000_0100);
        do_miss(32'h0000_0100, 16'hFFFF, 1'b0, 32'h0);
        do_hit(32'h0000_0040);

        // Set 0 now holds tags of 0x000 and 0x100; add three more tags.
        do_miss(32'h0000_0080, 16'hFFFF, 1'b0, 32'h0);
        do_miss(32'h0000_0180, 16'hFFFF, 1'b0, 32'h0);
        do_miss(32'h0000_0200, 16'hFFFF, 1'b0, 32'h0);
        do_hit(32'h0000_0080);
        do_hit(32'h0000_0104);
        do_hit(32'h0000_0200);
        do_miss(32'h0000_0000, 16'hFFFF, 1'b0, 32'h0);
        do_hit(32'h0000_0004);

        // Asynchronous reset after two words of a fill.
        ReadEnable_i  = 1'b1;
        ReadAddress_i = 32'h0000_0300;
        @(negedge clk);
        chk("rmiss_ready", 32'(Ready_o), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            MemDataReady_i = 1'b1;
            MemDataIn_i    = memw(32'h0000_0300 + 32'(4 * i));
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b1;
        #1;
        chk("async_ready", 32'(Ready_o), 32'd0);
        chk("async_req", 32'(MemReadRequest_o), 32'd0);
        chk("async_instr", Instruction_o, 32'h0);
        chk("async_addr", MemReadAddress_o, 32'h0);
        MemDataReady_i = 1'b0;
        ReadEnable_i   = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_ready", 32'(Ready_o), 32'd1);
        @(posedge clk); #1;
        do_miss(32'h0000_0300, 16'hFFFF, 1'b0, 32'h0);
        do_miss(32'h0000_000C, 16'hFFFF, 1'b0, 32'h0);
        do_hit(32'h0000_0308);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ucsbece154b_icache.md
Name: ucsbece154b_icache

Overview:
Set-associative, read-only instruction cache between the fetch stage and main memory. It answers fetch lookups, and on a hit it returns the instruction in the same cycle. On a miss it deasserts Ready_o, which drives the controller's Ready_F stall input, and refills the block by burst read from memory. Ready_o is the other end of the controller's Ready_F stall handshake.

Parameters:
NUM_SETS, 8, number of sets (power of 2)
NUM_WAYS, 4, ways per set
BLOCK_WORDS, 4, 32-bit words per block (power of 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ReadEnable_i  in  1  fetch lookup request
ReadAddress_i  in  32  fetch PC, word-aligned
Instruction_o  out  32  fetched instruction
Ready_o  out  1  instruction valid; low = stall fetch/decode (to Ready_F)
MemReadRequest_o  out  1  one-cycle burst request pulse
MemReadAddress_o  out  32  block-aligned burst address
MemDataIn_i  in  32  burst data word
MemDataReady_i  in  1  MemDataIn_i valid this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Address split: [1:0] ignored; next log2(BLOCK_WORDS) bits = word offset; next log2(NUM_SETS) bits = index; remaining bits = tag.
- Reset state: all valid bits cleared, round-robin pointers = 0, FSM = IDLE. Outputs during reset: Ready_o=0, MemReadRequest_o=0, Instruction_o=0, MemReadAddress_o=0.
- IDLE, ReadEnable_i=0: Ready_o=1, Instruction_o=0.
- IDLE, ReadEnable_i=1 and hit (any valid way with matching tag): Ready_o=1 and Instruction_o=word, combinationally in the same cycle (zero-cycle latency).
- IDLE, ReadEnable_i=1 and miss: Ready_o=0. Latch tag, index and offset into a miss register. Go to REQ.
- REQ (1 cycle): MemReadRequest_o=1; MemReadAddress_o = miss address with offset and [1:0] zeroed. Ready_o=0. Go to FILL.
- FILL: Ready_o=0.
  - Each cycle with MemDataReady_i=1: write MemDataIn_i to the victim way at word counter position, then increment the counter. Words arrive in order from word 0; gaps between words are allowed.
  - After BLOCK_WORDS words: set valid, write tag, advance the set's round-robin pointer. Go to DONE.
- DONE (1 cycle): Ready_o=1; Instruction_o = latched requested word. Go to IDLE.
- Victim selection: lowest-numbered invalid way first. If all ways are valid, use the set's round-robin pointer (mod NUM_WAYS).
- ReadAddress_i may change during a miss (e.g. controller flush on a mispredict):
  - the fill completes unaltered into the latched set;
  - DONE still presents the latched word for one cycle;
  - the new address is looked up on the following cycle.
- MemDataReady_i outside FILL is ignored.
- Reset mid-fill: aborts immediately; the partial block is never marked valid.
- The counter width is log2(BLOCK_WORDS)+1 bits, so BLOCK_WORDS is reached without wrap.

Optional Feature:
ICACHE_EARLY_RESTART_EN
- Defined: during FILL, in the cycle the requested word arrives (counter == latched offset and MemDataReady_i=1), drive Ready_o=1 and Instruction_o=MemDataIn_i. The rest of the fill continues with Ready_o=0, and DONE does not re-present the word (DONE drives Ready_o=0 for its one cycle).
- Undefined: behaviour exactly as in Behaviour above.

Test Plan:
- Cold miss: reset, read 0x0000_0008 -> Ready_o=0; MemReadRequest_o pulses 1 cycle with address 0x0000_0000. Memory returns 0xA0,0xA1,0xA2,0xA3 -> DONE gives Instruction_o=0xA2, Ready_o=1.
- Hit after fill: read 0x0000_000C -> same cycle Ready_o=1, Instruction_o=0xA3, MemReadRequest_o stays 0.
- Replacement: fill 5 distinct tags into set 0 (addresses 0x000,0x080,0x100,0x180,0x200 with defaults) -> the 5th evicts way 0. Re-read 0x000 -> miss; re-read 0x080 -> hit.
- Gapped burst: MemDataReady_i toggles 1,0,0,1,1,0,1 -> exactly 4 words captured in order; DONE occurs 1 cycle after the 4th word.
- Flush during fill: after the miss on 0x40, change ReadAddress_i to 0x100 mid-FILL -> the 0x40 block becomes valid; the following cycle misses on 0x100 and issues a new request.
- Async reset mid-FILL after 2 words -> Ready_o=0 immediately. After release, read the same address -> miss; new request issued.
